mac_share_sched: RTL and testbench
==================================

# mac_share_sched

Round-robin scheduler that time-shares one pipelined 9x9 unsigned multiply-accumulate datapath among four requesters, each with its own 18-bit accumulator. It sits between up to four operand producers and a single `a*b + acc` resource in the microbenchmark designs. It provides valid/ready issue handshakes, a 3-cycle result pipeline, and a drain-then-clear sequence for resetting all accumulators.

## Interface
- `BITS0`, default 9: operand width.
- `BITS2`, default 18: product and accumulator width (`2*BITS0`).
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `sched_en`  in  1: permits new grants when high.
- `clr_all`  in  1: pulse; requests the drain-then-clear sequence.
- `req_valid`  in  4: per-requester operation valid.
- `req_clr`  in  4: per-requester flag; the operation starts from 0 instead of the accumulator.
- `req_a`, `req_b`  in  4*BITS0 each: operands, requester i at `[i*BITS0 +: BITS0]`.
- `req_ready`  out  4: one-hot grant, combinational.
- `res_valid`  out  1: result strobe.
- `res_id`  out  2: requester index of the result.
- `res_data`  out  BITS2: updated accumulator value.
- `acc_out`  out  4*BITS2: all accumulators, registered.
- `acc_ovf`  out  4: sticky accumulator carry-out flags.
- `busy`  out  1: high whenever the state is not RUN or the pipeline is non-empty.

## Operation
- FSM states: RUN, DRAIN, CLEAR. Reset state is RUN.
- RUN:
  - Grant only when `sched_en`=1 and no `clr_all` is pending.
  - `clr_all` moves the FSM to DRAIN. The request latches into a pending bit, so a one-cycle pulse is sufficient.
- DRAIN:
  - No grants.
  - When stages s1 and s2 are both empty and the s3 writeback is done, go to CLEAR.
- CLEAR:
  - One cycle. All accumulators and `acc_ovf` go to 0, and the pending bit clears.
  - Next state is RUN.
- Arbitration:
  - Rotating priority starting at `ptr`. `req_ready[i]`=1 for the first i (from `ptr`, wrapping) with `req_valid[i]`=1.
  - A handshake is `req_valid[i] & req_ready[i]`. On a handshake, `ptr` becomes `i+1` mod 4. With no handshake, `ptr` holds.
  - Requesters hold `req_valid`, operands and `req_clr` stable until accepted.
- Pipeline:
  - s1 registers `a`, `b`, `clr` and `id`.
  - s2 registers the product `a*b` (BITS2 wide, unsigned, exact; max 511*511 = 261121).
  - s3 performs `acc[id] <= (clr ? 0 : acc[id]) + prod` mod 2^BITS2, and registers `res_valid`, `res_id` and `res_data` = the new value.
- Overflow:
  - A carry out of the s3 add sets `acc_ovf[id]`.
  - An op with `clr`=1 sets `acc_ovf[id]` to its own carry, which is always 0.
- Read-modify-write happens in a single stage (s3), so back-to-back ops from the same requester need no forwarding or stall.
- `sched_en` low: grants stop and the pipeline keeps draining.

## Timing
- Reset values:
  - `req_ready`=0 (combinational: 0 while `reset` is asserted)
  - `res_valid`=0, `res_id`=0, `res_data`=0
  - `acc_out`=0, `acc_ovf`=0
  - `ptr`=0, pipeline valids=0, pending=0
  - state=RUN
- Latency: a handshake in cycle N gives `res_valid`=1 in cycle N+3 (after 3 rising edges). `acc_out` updates on the same edge.
- Throughput: one accepted op per cycle. `res_valid` is a single-cycle pulse per op.
- `clr_all` arriving in the same cycle as a handshake: that op is accepted, and the FSM enters DRAIN on the next edge. That op lands before CLEAR.
- `clr_all` while already in DRAIN or CLEAR: ignored. The sequence is not restarted, and no second clear is queued.
- `busy`=1 from the edge after `clr_all` until the cycle after CLEAR. `busy` also reads 1 in RUN while any pipeline valid is set.
- Asynchronous reset mid-operation: in-flight ops are discarded with no `res_valid`, and all state returns to reset values.

## Test plan
- Reset, then `req_valid`=0001, a=3, b=5, `clr`=1, handshake at cycle 0 -> `res_valid`=1 at cycle 3, `res_id`=0, `res_data`=15. A second op a=2, b=4 -> `res_data`=23.
- All four valid continuously with `sched_en`=1 -> grants go 0,1,2,3,0,... one per cycle. Results appear in the same order, 3 cycles later.
- Requester 2 issues a=511, b=511 twice (first with `clr`=1) -> results 261121, then 260098 (522242 mod 262144). `acc_ovf[2]`=1 after the second result.
- Continuous traffic with a `clr_all` pulse -> grants stop the next cycle and the 3 in-flight results still emit. `acc_out` is all 0 and `acc_ovf`=0 one cycle later, then grants resume.
- Drop `sched_en` for 5 cycles under load -> `req_ready`=0 throughout, the pipeline drains, and `ptr` is unchanged. Arbitration resumes at the next requester in rotation.
- Assert `reset` one cycle after a handshake -> no `res_valid` and all outputs 0. After deassert, the first grant goes to requester 0.

Source files
------------

// File: rtl/mac_share_sched_if.sv
// Issue/result handshake bundle between the requesters and the shared MAC scheduler.
// Requester i uses bit i of the 4-bit vectors and operand slice [i*BITS0 +: BITS0].
interface mac_share_sched_if #(
    parameter int BITS0 = 9,
    parameter int BITS2 = 18
);
    logic [3:0]         req_valid;
    logic [3:0]         req_clr;
    logic [4*BITS0-1:0] req_a;
    logic [4*BITS0-1:0] req_b;
    logic [3:0]         req_ready;
    logic               res_valid;
    logic [1:0]         res_id;
    logic [BITS2-1:0]   res_data;

    modport master (
        output req_valid, req_clr, req_a, req_b,
        input  req_ready, res_valid, res_id, res_data
    );

    modport slave (
        input  req_valid, req_clr, req_a, req_b,
        output req_ready, res_valid, res_id, res_data
    );
endinterface

// File: rtl/mac_share_sched.sv
// Round-robin scheduler sharing one 3-stage a*b+acc pipeline among four requesters,
// with per-requester accumulators and a drain-then-clear sequence.
module mac_share_sched #(
    parameter int BITS0 = 9,
    parameter int BITS2 = 18
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sched_en,
    input  logic               clr_all,
    mac_share_sched_if.slave   bus,
    output logic [4*BITS2-1:0] acc_out,
    output logic [3:0]         acc_ovf,
    output logic               busy
);

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

    state_t           state;
    logic             pending;
    logic [1:0]       ptr;

    logic [BITS0-1:0] op_a [4];
    logic [BITS0-1:0] op_b [4];
    logic [3:0]       grant;
    logic [1:0]       gidx;
    logic [1:0]       idx;
    logic             found;
    logic             grant_ok;
    logic             hs;

    logic             v1;
    logic [BITS0-1:0] a1;
    logic [BITS0-1:0] b1;
    logic             clr1;
    logic [1:0]       id1;

    logic             v2;
    logic [BITS2-1:0] prod2;
    logic             clr2;
    logic [1:0]       id2;

    logic [BITS2-1:0] acc [4];
    logic [BITS2-1:0] base;
    logic [BITS2:0]   sum;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            op_a[i] = bus.req_a[i*BITS0 +: BITS0];
            op_b[i] = bus.req_b[i*BITS0 +: BITS0];
        end
    end

    assign grant_ok = !reset && (state == RUN) && sched_en && !pending;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.req_valid[idx]) begin
                found       = 1'b1;
                gidx        = idx;
                grant[idx]  = 1'b1;
            end
        end
        if (!grant_ok) begin
            grant = '0;
        end
    end

    assign hs            = found && grant_ok;
    assign bus.req_ready = grant;
    assign busy          = (state != RUN) || v1 || v2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            pending <= 1'b0;
            ptr     <= '0;
        end else begin
            if (hs) begin
                ptr <= gidx + 2'd1;
            end
            case (state)
                RUN: begin
                    if (clr_all) begin
                        state   <= DRAIN;
                        pending <= 1'b1;
                    end
                end
                DRAIN: begin
                    // s3 has already written back once s1 and s2 are both empty.
                    if (!v1 && !v2) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    state   <= RUN;
                    pending <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1    <= 1'b0;
            a1    <= '0;
            b1    <= '0;
            clr1  <= 1'b0;
            id1   <= '0;
            v2    <= 1'b0;
            prod2 <= '0;
            clr2  <= 1'b0;
            id2   <= '0;
        end else begin
            v1 <= hs;
            if (hs) begin
                a1   <= op_a[gidx];
                b1   <= op_b[gidx];
                clr1 <= bus.req_clr[gidx];
                id1  <= gidx;
            end
            v2 <= v1;
            if (v1) begin
                prod2 <= {{(BITS2-BITS0){1'b0}}, a1} * {{(BITS2-BITS0){1'b0}}, b1};
                clr2  <= clr1;
                id2   <= id1;
            end
        end
    end

    always_comb begin
        base = clr2 ? '0 : acc[id2];
        sum  = {1'b0, base} + {1'b0, prod2};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                acc[i] <= '0;
            end
            acc_ovf       <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_data  <= '0;
        end else if (state == CLEAR) begin
            for (int unsigned i = 0; i < 4; i++) begin
                acc[i] <= '0;
            end
            acc_ovf       <= '0;
            bus.res_valid <= 1'b0;
        end else begin
            bus.res_valid <= v2;
            if (v2) begin
                acc[id2]     <= sum[BITS2-1:0];
                acc_ovf[id2] <= sum[BITS2] | (!clr2 && acc_ovf[id2]);
                bus.res_id   <= id2;
                bus.res_data <= sum[BITS2-1:0];
            end
        end
    end

    always_comb begin
        acc_out = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            acc_out[i*BITS2 +: BITS2] = acc[i];
        end
    end

endmodule

// File: tb/tb_mac_share_sched.sv
// Directed bench for mac_share_sched: a reference model predicts grants and results,
// expected results are queued at issue and popped when the DUT strobes res_valid.
module tb_mac_share_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        sched_en;
    logic        clr_all;
    logic [71:0] acc_out;
    logic [3:0]  acc_ovf;
    logic        busy;

    mac_share_sched_if #(.BITS0(9), .BITS2(18)) bus ();

    mac_share_sched #(.BITS0(9), .BITS2(18)) dut (
        .clock    (clock),
        .reset    (reset),
        .sched_en (sched_en),
        .clr_all  (clr_all),
        .bus      (bus),
        .acc_out  (acc_out),
        .acc_ovf  (acc_ovf),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  id;
        logic [17:0] data;
        logic        ovf;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        grant_en;
    logic [1:0]  mptr;
    logic [17:0] macc [4];
    logic        movf [4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        mptr = 2'd0;
        for (int i = 0; i < 4; i++) begin
            macc[i] = '0;
            movf[i] = 1'b0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int id, input int a, input int b, input logic c);
        bus.req_a[id*9 +: 9] = 9'(a);
        bus.req_b[id*9 +: 9] = 9'(b);
        bus.req_clr[id]      = c;
    endtask

    task automatic issue(input int id, input int a, input int b, input logic c);
        set_op(id, a, b, c);
        bus.req_valid = 4'b0001 << id;
        step(1);
        bus.req_valid = '0;
    endtask

    // Model evaluated mid-cycle: predicts req_ready, records accepted ops, checks results.
    always @(negedge clock) begin : mon
        logic [3:0]  exp_rdy;
        logic        fnd;
        logic [1:0]  ix;
        logic [1:0]  hid;
        logic [17:0] b0;
        logic [18:0] s;
        logic        exp_v;
        exp_t        e;
        exp_t        n;

        cyc++;
        exp_rdy = '0;
        fnd     = 1'b0;
        hid     = '0;
        if (!reset && grant_en && sched_en) begin
            for (int k = 0; k < 4; k++) begin
                ix = mptr + 2'(k);
                if (!fnd && bus.req_valid[ix]) begin
                    fnd          = 1'b1;
                    hid          = ix;
                    exp_rdy[ix]  = 1'b1;
                end
            end
        end
        chk("req_ready", {124'd0, bus.req_ready}, {124'd0, exp_rdy});
        if (fnd) begin
            b0   = bus.req_clr[hid] ? 18'd0 : macc[hid];
            s    = {1'b0, b0} + 19'(bus.req_a[hid*9 +: 9]) * 19'(bus.req_b[hid*9 +: 9]);
            movf[hid] = s[18] | (!bus.req_clr[hid] && movf[hid]);
            macc[hid] = s[17:0];
            n.id   = hid;
            n.data = s[17:0];
            n.ovf  = movf[hid];
            n.t    = cyc;
            q.push_back(n);
            mptr = hid + 2'd1;
        end

        exp_v = (q.size() > 0) && (q[0].t + 3 == cyc);
        chk("res_valid", {127'd0, bus.res_valid}, {127'd0, exp_v});
        if (exp_v) begin
            e = q.pop_front();
            if (bus.res_valid) begin
                chk("res_id", {126'd0, bus.res_id}, {126'd0, e.id});
                chk("res_data", {110'd0, bus.res_data}, {110'd0, e.data});
                chk("acc_ovf_bit", {127'd0, acc_ovf[e.id]}, {127'd0, e.ovf});
                chk("acc_out_slice", {110'd0, acc_out[e.id*18 +: 18]}, {110'd0, e.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d observed=running expected=finished", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        reset         = 1'b1;
        sched_en      = 1'b1;
        clr_all       = 1'b0;
        grant_en      = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_clr   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        model_reset();
        step(2);
        chk("rst_res_valid", {127'd0, bus.res_valid}, 128'd0);
        chk("rst_res_id", {126'd0, bus.res_id}, 128'd0);
        chk("rst_res_data", {110'd0, bus.res_data}, 128'd0);
        chk("rst_acc_out", {56'd0, acc_out}, 128'd0);
        chk("rst_acc_ovf", {124'd0, acc_ovf}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        bus.req_valid = '0;
        reset         = 1'b0;
        step(1);

        // Basic MAC on requester 0: 3*5 from zero, then +2*4.
        issue(0, 3, 5, 1'b1);
        chk("busy_inflight", {127'd0, busy}, 128'd1);
        issue(0, 2, 4, 1'b0);
        step(5);
        chk("basic_busy_idle", {127'd0, busy}, 128'd0);
        chk("basic_acc0", {110'd0, acc_out[17:0]}, 128'd23);

        // All four requesters continuously valid: one grant per cycle in rotation.
        for (int i = 0; i < 4; i++) set_op(i, i + 1, i + 7, 1'b0);
        bus.req_valid = 4'b1111;
        step(12);
        bus.req_valid = '0;
        step(5);

        // Accumulator wrap and sticky overflow on requester 2.
        issue(2, 511, 511, 1'b1);
        issue(2, 511, 511, 1'b0);
        step(5);
        chk("ovf_acc2", {110'd0, acc_out[36 +: 18]}, 128'd260098);
        chk("ovf_flag2", {127'd0, acc_ovf[2]}, 128'd1);

        // clr_all under continuous traffic, with a second pulse during DRAIN ignored.
        for (int i = 0; i < 4; i++) set_op(i, i + 2, 3, 1'b0);
        bus.req_valid = 4'b1111;
        step(3);
        clr_all = 1'b1;
        step(1);
        clr_all  = 1'b0;
        grant_en = 1'b0;
        model_reset();
        mptr = q[q.size()-1].id + 2'd1;
        chk("drain_busy", {127'd0, busy}, 128'd1);
        step(1);
        clr_all = 1'b1;
        step(1);
        clr_all = 1'b0;
        step(1);
        chk("clear_busy", {127'd0, busy}, 128'd1);
        step(1);
        grant_en = 1'b1;
        chk("clear_acc_out", {56'd0, acc_out}, 128'd0);
        chk("clear_acc_ovf", {124'd0, acc_ovf}, 128'd0);
        chk("clear_busy_done", {127'd0, busy}, 128'd0);
        step(6);
        bus.req_valid = '0;
        step(5);

        // sched_en dropped for 5 cycles under load; rotation resumes where it left off.
        bus.req_valid = 4'b1111;
        step(3);
        sched_en = 1'b0;
        step(4);
        chk("sched_off_busy", {127'd0, busy}, 128'd0);
        step(1);
        sched_en = 1'b1;
        step(6);
        bus.req_valid = '0;
        step(5);

        // Reset one cycle after a handshake discards the in-flight op.
        issue(0, 7, 9, 1'b1);
        reset = 1'b1;
        q.delete();
        model_reset();
        step(1);
        chk("mid_rst_res_valid", {127'd0, bus.res_valid}, 128'd0);
        chk("mid_rst_res_data", {110'd0, bus.res_data}, 128'd0);
        chk("mid_rst_acc_out", {56'd0, acc_out}, 128'd0);
        chk("mid_rst_acc_ovf", {124'd0, acc_ovf}, 128'd0);
        chk("mid_rst_busy", {127'd0, busy}, 128'd0);
        step(3);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 10 + i, 2, 1'b0);
        bus.req_valid = 4'b1111;
        step(1);
        bus.req_valid = '0;
        step(5);

        chk("queue_empty", 128'(q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
